// File: rtl/decoder_pipe_ctrl.sv
// decoder_pipe_ctrl
//   ID-stage decoder for the pipelined MIPS core. Decodes the IF/ID
//   instruction, registers the control bundle and register fields into the
//   ID/EX boundary, and generates the pipeline interlocks:
//     - load-use hazard  : one-cycle stall, bubble inserted into EX
//     - multi-cycle mul  : EX held for MUL_LAT cycles, front end stalled
//     - branch flush     : ID instruction killed, mul hold abandoned
//
// Ports
//   clk_i, rst_i               clock (rising edge), async active-low reset
//   instr_i, instr_valid_i     instruction from IF/ID and its valid flag
//   flush_i                    kill the ID instruction this edge
//   stall_o                    hold PC and IF/ID (combinational)
//   mul_busy_o                 multiply still occupying EX
//   ex_*_o                     registered ID/EX contents
module decoder_pipe_ctrl #(
    parameter int ALU_OP_W   = 4,
    parameter int REG_ADDR_W = 5,
    parameter int MUL_LAT    = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           instr_i,
    input  logic                  instr_valid_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  ex_valid_o,
    output logic                  ex_reg_write_o,
    output logic                  ex_alu_src_o,
    output logic                  ex_reg_dst_o,
    output logic                  ex_branch_o,
    output logic                  ex_shift_o,
    output logic                  ex_se_o,
    output logic                  ex_mem_read_o,
    output logic                  ex_mem_write_o,
    output logic                  ex_mem_to_reg_o,
    output logic [ALU_OP_W-1:0]   ex_alu_op_o,
    output logic [REG_ADDR_W-1:0] ex_rs_o,
    output logic [REG_ADDR_W-1:0] ex_rt_o,
    output logic [REG_ADDR_W-1:0] ex_rd_o,
    output logic                  ex_illegal_o,
    output logic                  mul_busy_o
);

    // Counter only has to hold MUL_LAT-1.
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_MUL   = 6'b011000;

    typedef struct packed {
        logic                  valid;
        logic                  illegal;
        logic                  reg_write;
        logic                  alu_src;
        logic                  reg_dst;
        logic                  branch;
        logic                  shift;
        logic                  se;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic [ALU_OP_W-1:0]   alu_op;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
    } idex_t;

    idex_t             ex_q, ex_d, dec;
    logic [CNT_W-1:0]  mul_cnt_q, mul_cnt_d;
    logic              dec_mul, reads_rs, reads_rt;
    logic              mul_busy, load_use;
    logic [5:0]        op, fn;
    logic [REG_ADDR_W-1:0] id_rs, id_rt, id_rd;

    // shamt is consumed by the EX shifter straight from the instruction word.
    logic unused_shamt;
    assign unused_shamt = ^instr_i[10:6];

    assign op    = instr_i[31:26];
    assign fn    = instr_i[5:0];
    assign id_rs = REG_ADDR_W'(instr_i[25:21]);
    assign id_rt = REG_ADDR_W'(instr_i[20:16]);
    assign id_rd = REG_ADDR_W'(instr_i[15:11]);

    // ---------------------------------------------------------------- decode
    always_comb begin
        dec      = '0;
        dec_mul  = 1'b0;
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        dec.valid = 1'b1;
        case (op)
            OP_RTYPE: begin
                dec.alu_op    = ALU_OP_W'(4'b0010);
                dec.reg_dst   = 1'b1;
                dec.reg_write = 1'b1;
                dec.shift     = (fn == FN_SRA);
                reads_rs      = 1'b1;
                reads_rt      = 1'b1;
                if (fn == FN_MUL) begin
                    dec.alu_op = ALU_OP_W'(4'b1000);
                    dec_mul    = 1'b1;
                end
            end
            OP_BEQ, OP_BNE: begin
                dec.alu_op = (op == OP_BEQ) ? ALU_OP_W'(4'b0001) : ALU_OP_W'(4'b0101);
                dec.branch = 1'b1;
                dec.se     = 1'b1;
                reads_rs   = 1'b1;
                reads_rt   = 1'b1;
            end
            OP_ADDI, OP_SLTIU, OP_ORI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.se        = (op == OP_ADDI);
                dec.alu_op    = (op == OP_ADDI)  ? ALU_OP_W'(4'b0000) :
                                (op == OP_SLTIU) ? ALU_OP_W'(4'b0110) :
                                                   ALU_OP_W'(4'b0100);
                reads_rs      = 1'b1;
            end
            OP_LUI: begin
                // lui takes no register source, so it never load-use stalls.
                dec.alu_op    = ALU_OP_W'(4'b0011);
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.se        = 1'b1;
            end
            OP_LW: begin
                dec.alu_src    = 1'b1;
                dec.se         = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                reads_rs       = 1'b1;
            end
            OP_SW: begin
                dec.alu_src   = 1'b1;
                dec.se        = 1'b1;
                dec.mem_write = 1'b1;
                reads_rs      = 1'b1;
                reads_rt      = 1'b1;
            end
            default: begin
                // Undecodable: travel as a bubble tagged illegal.
                dec.valid   = 1'b0;
                dec.illegal = 1'b1;
            end
        endcase
        if (dec.valid) begin
            dec.rs = id_rs;
            dec.rt = id_rt;
            dec.rd = id_rd;
        end
    end

    // --------------------------------------------------------------- hazards
    assign mul_busy = (mul_cnt_q != '0);

    assign load_use = instr_valid_i && ex_q.valid && ex_q.mem_read && (ex_q.rt != '0) &&
                      ((reads_rs && (id_rs == ex_q.rt)) || (reads_rt && (id_rt == ex_q.rt)));

    // A flush overrides every stall reason in its cycle.
    assign stall_o    = !flush_i && (mul_busy || load_use);
    assign mul_busy_o = mul_busy;

    // ------------------------------------------------------------ next state
    always_comb begin
        ex_d      = ex_q;
        mul_cnt_d = mul_cnt_q;
        if (flush_i) begin
            ex_d      = '0;
            mul_cnt_d = '0;
        end else if (mul_busy) begin
            mul_cnt_d = mul_cnt_q - CNT_W'(1);
        end else if (!instr_valid_i || load_use) begin
            ex_d = '0;
        end else begin
            ex_d = dec;
            if (dec_mul) mul_cnt_d = CNT_W'(MUL_LAT - 1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q      <= '0;
            mul_cnt_q <= '0;
        end else begin
            ex_q      <= ex_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    assign ex_valid_o      = ex_q.valid;
    assign ex_illegal_o    = ex_q.illegal;
    assign ex_reg_write_o  = ex_q.reg_write;
    assign ex_alu_src_o    = ex_q.alu_src;
    assign ex_reg_dst_o    = ex_q.reg_dst;
    assign ex_branch_o     = ex_q.branch;
    assign ex_shift_o      = ex_q.shift;
    assign ex_se_o         = ex_q.se;
    assign ex_mem_read_o   = ex_q.mem_read;
    assign ex_mem_write_o  = ex_q.mem_write;
    assign ex_mem_to_reg_o = ex_q.mem_to_reg;
    assign ex_alu_op_o     = ex_q.alu_op;
    assign ex_rs_o         = ex_q.rs;
    assign ex_rt_o         = ex_q.rt;
    assign ex_rd_o         = ex_q.rd;

endmodule

// File: tb/tb_decoder_pipe_ctrl.sv
// Directed bench for decoder_pipe_ctrl (default parameters, MUL_LAT=3).
module tb_decoder_pipe_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] instr_i;
    logic        instr_valid_i;
    logic        flush_i;
    logic        stall_o, ex_valid_o, ex_reg_write_o, ex_alu_src_o, ex_reg_dst_o;
    logic        ex_branch_o, ex_shift_o, ex_se_o, ex_mem_read_o, ex_mem_write_o;
    logic        ex_mem_to_reg_o, ex_illegal_o, mul_busy_o;
    logic [3:0]  ex_alu_op_o;
    logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADDI   = 32'h21280005; // addi $t0,$t1,5
    localparam logic [31:0] LW_T0  = 32'h8E080000; // lw   $t0,0($s0)
    localparam logic [31:0] LW_Z   = 32'h8E000000; // lw   $zero,0($s0)
    localparam logic [31:0] ADD_T0 = 32'h010A4820; // add  $t1,$t0,$t2
    localparam logic [31:0] ADD_Z  = 32'h000A4820; // add  $t1,$zero,$t2
    localparam logic [31:0] MUL    = 32'h014B4818; // mul  $t1,$t2,$t3
    localparam logic [31:0] SRA    = 32'h000A4883; // sra  $t1,$t2,2
    localparam logic [31:0] BNE    = 32'h15090004; // bne  $t0,$t1,4
    localparam logic [31:0] LUI    = 32'h3D080001; // lui with rs field = $t0
    localparam logic [31:0] SW_T0  = 32'hAE080000; // sw   $t0,0($s0)
    localparam logic [31:0] ILL    = 32'hFC000000; // opcode 111111

    decoder_pipe_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i),
        .instr_valid_i(instr_valid_i), .flush_i(flush_i), .stall_o(stall_o),
        .ex_valid_o(ex_valid_o), .ex_reg_write_o(ex_reg_write_o),
        .ex_alu_src_o(ex_alu_src_o), .ex_reg_dst_o(ex_reg_dst_o),
        .ex_branch_o(ex_branch_o), .ex_shift_o(ex_shift_o), .ex_se_o(ex_se_o),
        .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
        .ex_mem_to_reg_o(ex_mem_to_reg_o), .ex_alu_op_o(ex_alu_op_o),
        .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
        .ex_illegal_o(ex_illegal_o), .mul_busy_o(mul_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic v);
        instr_i       = ins;
        instr_valid_i = v;
        #1;
    endtask

    initial begin
        rst_i = 1'b0; instr_i = '0; instr_valid_i = 1'b0; flush_i = 1'b0;
        tick(); tick();
        chk("rst_valid",   32'(ex_valid_o), 0);
        chk("rst_regwr",   32'(ex_reg_write_o), 0);
        chk("rst_stall",   32'(stall_o), 0);
        chk("rst_mulbusy", 32'(mul_busy_o), 0);
        #2 rst_i = 1'b1;

        // addi
        drive(ADDI, 1'b1);
        chk("addi_stall", 32'(stall_o), 0);
        tick();
        chk("addi_valid",  32'(ex_valid_o), 1);
        chk("addi_aluop",  32'(ex_alu_op_o), 4'b0000);
        chk("addi_alusrc", 32'(ex_alu_src_o), 1);
        chk("addi_regwr",  32'(ex_reg_write_o), 1);
        chk("addi_se",     32'(ex_se_o), 1);
        chk("addi_regdst", 32'(ex_reg_dst_o), 0);
        chk("addi_rs",     32'(ex_rs_o), 9);
        chk("addi_rt",     32'(ex_rt_o), 8);

        // lw $t0 then add reading $t0: one stall cycle, bubble, then add
        drive(LW_T0, 1'b1);
        chk("lw_stall", 32'(stall_o), 0);
        tick();
        chk("lw_memrd", 32'(ex_mem_read_o), 1);
        chk("lw_m2r",   32'(ex_mem_to_reg_o), 1);
        chk("lw_rt",    32'(ex_rt_o), 8);
        drive(ADD_T0, 1'b1);
        chk("lu_stall", 32'(stall_o), 1);
        tick();
        chk("lu_bubble_valid", 32'(ex_valid_o), 0);
        chk("lu_bubble_memrd", 32'(ex_mem_read_o), 0);
        chk("lu_stall_gone",   32'(stall_o), 0);
        tick();
        chk("add_valid",  32'(ex_valid_o), 1);
        chk("add_rs",     32'(ex_rs_o), 8);
        chk("add_rt",     32'(ex_rt_o), 10);
        chk("add_rd",     32'(ex_rd_o), 9);
        chk("add_aluop",  32'(ex_alu_op_o), 4'b0010);
        chk("add_regdst", 32'(ex_reg_dst_o), 1);

        // lw $zero then consumer of $zero: no stall
        drive(LW_Z, 1'b1);
        tick();
        chk("lwz_rt", 32'(ex_rt_o), 0);
        drive(ADD_Z, 1'b1);
        chk("lwz_stall", 32'(stall_o), 0);
        tick();
        chk("addz_valid", 32'(ex_valid_o), 1);

        // lui reads no register: no stall behind lw $t0
        drive(LW_T0, 1'b1);
        tick();
        drive(LUI, 1'b1);
        chk("lui_stall", 32'(stall_o), 0);
        tick();
        chk("lui_aluop", 32'(ex_alu_op_o), 4'b0011);

        // sw reads rt: stalls behind lw $t0
        drive(LW_T0, 1'b1);
        tick();
        drive(SW_T0, 1'b1);
        chk("sw_stall", 32'(stall_o), 1);
        tick();
        tick();
        chk("sw_memwr", 32'(ex_mem_write_o), 1);
        chk("sw_regwr", 32'(ex_reg_write_o), 0);

        // invalid slot behind lw: no hazard evaluated, bubble loaded
        drive(LW_T0, 1'b1);
        tick();
        drive(ADD_T0, 1'b0);
        chk("inv_stall", 32'(stall_o), 0);
        tick();
        chk("inv_valid",   32'(ex_valid_o), 0);
        chk("inv_illegal", 32'(ex_illegal_o), 0);

        // mul with MUL_LAT=3
        drive(MUL, 1'b1);
        chk("mul_stall0", 32'(stall_o), 0);
        tick();
        drive(ADDI, 1'b1);
        chk("mul_aluop1", 32'(ex_alu_op_o), 4'b1000);
        chk("mul_busy1",  32'(mul_busy_o), 1);
        chk("mul_stall1", 32'(stall_o), 1);
        tick();
        chk("mul_aluop2", 32'(ex_alu_op_o), 4'b1000);
        chk("mul_busy2",  32'(mul_busy_o), 1);
        chk("mul_stall2", 32'(stall_o), 1);
        tick();
        chk("mul_aluop3", 32'(ex_alu_op_o), 4'b1000);
        chk("mul_busy3",  32'(mul_busy_o), 0);
        chk("mul_stall3", 32'(stall_o), 0);
        tick();
        chk("mul_next_aluop",  32'(ex_alu_op_o), 4'b0000);
        chk("mul_next_alusrc", 32'(ex_alu_src_o), 1);

        // flush during mul hold
        drive(MUL, 1'b1);
        tick();
        chk("fl_busy_pre", 32'(mul_busy_o), 1);
        flush_i = 1'b1;
        #1;
        chk("fl_stall", 32'(stall_o), 0);
        tick();
        flush_i = 1'b0;
        drive(SRA, 1'b1);
        chk("fl_valid", 32'(ex_valid_o), 0);
        chk("fl_busy",  32'(mul_busy_o), 0);
        chk("fl_stall_after", 32'(stall_o), 0);

        // sra
        tick();
        chk("sra_shift", 32'(ex_shift_o), 1);
        chk("sra_se",    32'(ex_se_o), 0);
        chk("sra_aluop", 32'(ex_alu_op_o), 4'b0010);

        // bne
        drive(BNE, 1'b1);
        tick();
        chk("bne_aluop",  32'(ex_alu_op_o), 4'b0101);
        chk("bne_branch", 32'(ex_branch_o), 1);
        chk("bne_regwr",  32'(ex_reg_write_o), 0);
        chk("bne_se",     32'(ex_se_o), 1);

        // illegal opcode
        drive(ILL, 1'b1);
        tick();
        chk("ill_illegal", 32'(ex_illegal_o), 1);
        chk("ill_valid",   32'(ex_valid_o), 0);
        chk("ill_regwr",   32'(ex_reg_write_o), 0);

        // async reset mid-stream during a mul hold
        drive(MUL, 1'b1);
        tick();
        chk("rst2_busy_pre", 32'(mul_busy_o), 1);
        #2 rst_i = 1'b0;
        #1;
        chk("rst2_valid", 32'(ex_valid_o), 0);
        chk("rst2_aluop", 32'(ex_alu_op_o), 0);
        chk("rst2_rt",    32'(ex_rt_o), 0);
        chk("rst2_busy",  32'(mul_busy_o), 0);
        chk("rst2_stall", 32'(stall_o), 0);
        instr_valid_i = 1'b0;
        #1 rst_i = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_pipe_ctrl.md
Name: decoder_pipe_ctrl

Overview:
Pipelined successor to the single-cycle instruction decoder. Decodes a full 32-bit MIPS instruction in ID and registers the control bundle plus register addresses into the ID/EX boundary. Adds load-use hazard detection, branch flush, and a multi-cycle multiply interlock. Sits between the IF/ID register and the EX-stage ALU/ALU_Ctrl in the pipelined CPU.

Parameters:
ALU_OP_W, 4, width of the ALU op field; must be >= 4.
REG_ADDR_W, 5, register-file address width.
MUL_LAT, 3, EX-stage cycles occupied by mul; must be >= 1.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
instr_i  in  32  instruction from the IF/ID register
instr_valid_i  in  1  instr_i holds a real instruction; 0 means bubble
flush_i  in  1  branch taken/mispredict: kill the ID instruction
stall_o  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid_o  out  1  ID/EX holds a real instruction
ex_reg_write_o, ex_alu_src_o, ex_reg_dst_o, ex_branch_o, ex_shift_o, ex_se_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o  out  1 each  registered control
ex_alu_op_o  out  ALU_OP_W  registered ALU op
ex_rs_o, ex_rt_o, ex_rd_o  out  REG_ADDR_W each  registered register fields
ex_illegal_o  out  1  registered: ID/EX holds an undecodable opcode (raised as a bubble)
mul_busy_o  out  1  multiply occupying EX

Behaviour:
- Reset (rst_i=0, asynchronous): all ex_* outputs 0, mul counter 0; stall_o and mul_busy_o are therefore 0.
- Decode table (op/funct -> alu_op, alu_src, reg_dst, reg_write, se, other):
  R-format op=000000 -> 0010, 0, 1, 1, x. shift=1 and se=0 when funct=000011 (sra).
  mul: R-format with funct=011000 -> alu_op 1000; otherwise as R-format.
  beq 000100 -> 0001, branch=1, reg_write=0, se=1. bne 000101 -> 0101, branch=1, reg_write=0, se=1.
  addi 001000 -> 0000, 1, 0, 1, se=1. sltiu 001011 -> 0110, se=0. lui 001111 -> 0011, se=1. ori 001101 -> 0100, se=0. All four: alu_src=1, reg_write=1.
  lw 100011 -> 0000, alu_src=1, se=1, mem_read=1, mem_to_reg=1, reg_write=1.
  sw 101011 -> 0000, alu_src=1, se=1, mem_write=1, reg_write=0.
  Any other opcode -> bubble (all control 0, ex_valid_o=0) with ex_illegal_o=1.
  Upper ALU op bits above bit 3 are 0.
- Bubble: every ex_* control output is 0; register fields are don't-care but held at 0.
- Load-use hazard (combinational): ex_valid_o & ex_mem_read_o & ex_rt_o!=0, and the ID instruction reads ex_rt_o.
  R-format, beq, bne and sw read rs and rt; I-format ALU ops and lw read rs only; lui reads nothing.
  Result: stall_o=1 and ID/EX loads a bubble next edge.
- Multiply interlock: when mul is loaded into ID/EX, the counter loads MUL_LAT-1.
  - While counter!=0: mul_busy_o=1, stall_o=1, ID/EX holds its contents, counter decrements each cycle.
  - MUL_LAT=1: no stall.
- Priority per edge: flush_i > mul hold > load-use > normal load.
  - flush_i=1: ID/EX <= bubble, counter <= 0, stall_o=0 in that cycle.
- instr_valid_i=0: ID/EX <= bubble, and no hazard is evaluated.
- Latency: 1 cycle from instr_i to ex_* outputs.

Test Plan:
- Reset mid-stream: assert rst_i=0 asynchronously between edges -> all ex_* outputs go to 0 immediately; stall_o=0.
- addi $t0,$t1,5 (0x21280005) -> next cycle ex_alu_op_o=0000, alu_src=1, reg_write=1, se=1, rt=8; stall_o stays 0.
- lw $t0,0($s0) followed by add $t1,$t0,$t2 -> stall_o=1 for exactly one cycle, then a bubble in EX, then the add with rs=8. Repeating with the consumer reading $zero gives no stall.
- mul (funct 011000) with MUL_LAT=3 -> mul_busy_o/stall_o high for 2 cycles with ID/EX held; the next instruction enters EX on the 3rd edge.
- flush_i during mul hold -> ID/EX becomes a bubble, counter is cleared, stall_o=0 the same cycle.
- Opcode 111111 -> ex_illegal_o=1 and ex_valid_o=0. sra (funct 000011) -> ex_shift_o=1, ex_se_o=0. bne -> ex_alu_op_o=0101, ex_branch_o=1, ex_reg_write_o=0.
